// File: rtl/dmac_channel_sequencer.sv
// Two-channel DMAC sequencer: arbitrates peripheral requests, owns the AHB bus request and
// retires each transfer on irq or watchdog abort. Define DMAC_ROUND_ROBIN_EN for round-robin arbitration.
module dmac_channel_sequencer #(
    parameter int WDOG_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] DmacReq,
    input  logic       C_config,
    input  logic       irq,
    input  logic       HGrant,
    output logic       HBusReq,
    output logic       con_en,
    output logic       con_sel,
    output logic       channel_en_1,
    output logic       channel_en_2,
    output logic [1:0] ReqAck,
    output logic       busy,
    output logic       err
);

    localparam int WDW = (WDOG_CYCLES > 0) ? $clog2(WDOG_CYCLES + 1) : 1;
    localparam logic [WDW-1:0] WDOG_LAST = WDW'((WDOG_CYCLES > 0) ? WDOG_CYCLES - 1 : 0);
    localparam bit WDOG_ON = (WDOG_CYCLES > 0);

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        WAIT_GNT,
        XFER,
        DONE,
        ABORT
    } state_e;

    state_e         state_q, state_d;
    logic           sel_q, sel_d;
    logic [WDW-1:0] wdog_q, wdog_d;
    logic           arbSel;
    logic           wdogExpired;

    logic       hBusReq_q, hBusReq_d;
    logic       conEn_q, conEn_d;
    logic       en1_q, en1_d;
    logic       en2_q, en2_d;
    logic [1:0] reqAck_q, reqAck_d;
    logic       busy_q, busy_d;
    logic       err_q, err_d;

`ifdef DMAC_ROUND_ROBIN_EN
    logic ptr_q, ptr_d;

    // The pointer names the channel served last, so on a tie the other channel wins.
    always_comb begin
        arbSel = (&DmacReq) ? ~ptr_q : ~DmacReq[0];
        ptr_d  = ptr_q;
        if (state_q == DONE || state_q == ABORT) begin
            ptr_d = sel_q;
        end
    end
`else
    always_comb begin
        arbSel = ~DmacReq[0];
    end
`endif

    assign wdogExpired = WDOG_ON && (wdog_q == WDOG_LAST);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        wdog_d  = wdog_q;
        case (state_q)
            IDLE: begin
                if (C_config && |DmacReq) begin
                    state_d = ARB;
                    sel_d   = arbSel;
                end
            end
            ARB: begin
                state_d = WAIT_GNT;
            end
            WAIT_GNT: begin
                if (HGrant) begin
                    state_d = XFER;
                    wdog_d  = '0;
                end
            end
            XFER: begin
                if (irq) begin
                    state_d = DONE;
                end else if (wdogExpired) begin
                    state_d = ABORT;
                end else if (WDOG_ON) begin
                    wdog_d = wdog_q + WDW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            ABORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it and stay Moore.
    always_comb begin
        hBusReq_d = (state_d == WAIT_GNT) || (state_d == XFER);
        conEn_d   = (state_d == ARB);
        en1_d     = (state_d == XFER) && !sel_d;
        en2_d     = (state_d == XFER) && sel_d;
        reqAck_d  = (state_d == DONE) ? (sel_d ? 2'b10 : 2'b01) : 2'b00;
        busy_d    = (state_d != IDLE);
        err_d     = (state_d == ABORT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= 1'b0;
            wdog_q    <= '0;
            hBusReq_q <= 1'b0;
            conEn_q   <= 1'b0;
            en1_q     <= 1'b0;
            en2_q     <= 1'b0;
            reqAck_q  <= 2'b00;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef DMAC_ROUND_ROBIN_EN
            ptr_q     <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            wdog_q    <= wdog_d;
            hBusReq_q <= hBusReq_d;
            conEn_q   <= conEn_d;
            en1_q     <= en1_d;
            en2_q     <= en2_d;
            reqAck_q  <= reqAck_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
`ifdef DMAC_ROUND_ROBIN_EN
            ptr_q     <= ptr_d;
`endif
        end
    end

    assign HBusReq      = hBusReq_q;
    assign con_en       = conEn_q;
    assign con_sel      = sel_q;
    assign channel_en_1 = en1_q;
    assign channel_en_2 = en2_q;
    assign ReqAck       = reqAck_q;
    assign busy         = busy_q;
    assign err          = err_q;

endmodule

// File: tb/tb_dmac_channel_sequencer.sv
// Directed bench for dmac_channel_sequencer with an 8-cycle watchdog; expected retirements
// (ack/err) are queued when a request is committed and popped when the DUT retires it.
module tb_dmac_channel_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] DmacReq;
    logic       C_config;
    logic       irq;
    logic       HGrant;
    logic       HBusReq;
    logic       con_en;
    logic       con_sel;
    logic       channel_en_1;
    logic       channel_en_2;
    logic [1:0] ReqAck;
    logic       busy;
    logic       err;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [1:0] ack;
        logic       err;
    } exp_t;

    exp_t sbQ[$];

    always #5 clk = ~clk;

    dmac_channel_sequencer #(.WDOG_CYCLES(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .DmacReq      (DmacReq),
        .C_config     (C_config),
        .irq          (irq),
        .HGrant       (HGrant),
        .HBusReq      (HBusReq),
        .con_en       (con_en),
        .con_sel      (con_sel),
        .channel_en_1 (channel_en_1),
        .channel_en_2 (channel_en_2),
        .ReqAck       (ReqAck),
        .busy         (busy),
        .err          (err)
    );

    function automatic logic [8:0] allOuts();
        return {HBusReq, con_en, con_sel, channel_en_1, channel_en_2, ReqAck, busy, err};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic cfg, input logic [1:0] req, input logic gnt, input logic irqIn);
        C_config = cfg;
        DmacReq  = req;
        HGrant   = gnt;
        irq      = irqIn;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic pushExp(input logic [1:0] ack, input logic e);
        exp_t x;
        x.ack = ack;
        x.err = e;
        sbQ.push_back(x);
    endtask

    task automatic checkRetire(input string tag);
        exp_t x;
        if (sbQ.size() == 0) begin
            total++;
            bad++;
            $error("[TB] FAIL %s observed=retirement expected=empty_scoreboard", tag);
        end else begin
            x = sbQ.pop_front();
            checkOutput({tag, "_ack"}, 16'(ReqAck), 16'(x.ack));
            checkOutput({tag, "_err"}, 16'(err), 16'(x.err));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        logic [2:0] order;
        int         xc;

        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_outs", 16'(allOuts()), 16'h0);
        rst = 1'b0;
        tick();

        // Unconfigured datapath must keep the sequencer idle.
        applyStimulus(1'b0, 2'b01, 1'b1, 1'b0);
        repeat (3) tick();
        checkOutput("gate_busy", 16'(busy), 16'h0);
        checkOutput("gate_outs", 16'(allOuts()), 16'h0);

        // Both requests held for three back-to-back transfers, starting from reset pointer.
`ifdef DMAC_ROUND_ROBIN_EN
        order = 3'b010;
`else
        order = 3'b000;
`endif
        applyStimulus(1'b1, 2'b11, 1'b1, 1'b0);
        tick();
        for (int t = 0; t < 3; t++) begin
            checkOutput($sformatf("b2b%0d_con_en", t), 16'(con_en), 16'h1);
            checkOutput($sformatf("b2b%0d_sel", t), 16'(con_sel), 16'(order[t]));
            pushExp(order[t] ? 2'b10 : 2'b01, 1'b0);
            tick();
            tick();
            irq = 1'b1;
            tick();
            irq = 1'b0;
            checkRetire($sformatf("b2b%0d", t));
            if (t == 2) DmacReq = 2'b00;
            tick();
            checkOutput($sformatf("b2b%0d_idle", t), 16'(busy), 16'h0);
            if (t < 2) tick();
        end

        // Single channel-2 request with immediate grant.
        applyStimulus(1'b1, 2'b10, 1'b1, 1'b0);
        tick();
        checkOutput("t1_con_en", 16'(con_en), 16'h1);
        checkOutput("t1_con_sel", 16'(con_sel), 16'h1);
        pushExp(2'b10, 1'b0);
        DmacReq = 2'b00;
        tick();
        checkOutput("t1_wait", 16'({HBusReq, channel_en_1, channel_en_2}), 16'b100);
        tick();
        checkOutput("t1_xfer", 16'({HBusReq, channel_en_1, channel_en_2}), 16'b101);
        repeat (5) tick();
        irq = 1'b1;
        tick();
        irq = 1'b0;
        checkRetire("t1");
        tick();
        checkOutput("t1_ack_once", 16'(ReqAck), 16'h0);
        checkOutput("t1_busy", 16'(busy), 16'h0);

        // Channel-1 request with grant held off for five cycles, then lost mid-transfer.
        applyStimulus(1'b1, 2'b01, 1'b0, 1'b0);
        tick();
        checkOutput("t2_con_sel", 16'(con_sel), 16'h0);
        pushExp(2'b01, 1'b0);
        DmacReq = 2'b00;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput($sformatf("t2_wait%0d", i),
                        16'({busy, HBusReq, channel_en_1, channel_en_2}), 16'b1100);
        end
        HGrant = 1'b1;
        tick();
        checkOutput("t2_en_rise", 16'({channel_en_1, channel_en_2}), 16'b10);
        HGrant = 1'b0;
        tick();
        checkOutput("t2_grant_loss", 16'({HBusReq, channel_en_1}), 16'b11);
        irq = 1'b1;
        tick();
        irq = 1'b0;
        checkRetire("t2");
        tick();

        // Watchdog abort after eight XFER cycles without irq.
        applyStimulus(1'b1, 2'b01, 1'b1, 1'b0);
        tick();
        pushExp(2'b00, 1'b1);
        DmacReq = 2'b00;
        tick();
        tick();
        xc = 1;
        for (int k = 0; k < 20 && channel_en_1; k++) begin
            tick();
            if (channel_en_1) xc++;
        end
        checkOutput("wd_cycles", 16'(xc), 16'd8);
        checkRetire("wd");
        tick();
        checkOutput("wd_idle", 16'({busy, err, ReqAck}), 16'h0);

        // irq on the eighth XFER cycle beats the watchdog.
        applyStimulus(1'b1, 2'b01, 1'b1, 1'b0);
        tick();
        pushExp(2'b01, 1'b0);
        DmacReq = 2'b00;
        tick();
        tick();
        repeat (7) tick();
        checkOutput("wd_irq_still_xfer", 16'(channel_en_1), 16'h1);
        irq = 1'b1;
        tick();
        irq = 1'b0;
        checkRetire("wd_irq");
        tick();
        checkOutput("wd_irq_idle", 16'({busy, err}), 16'h0);

        // Reset in the middle of a transfer drops everything at once.
        applyStimulus(1'b1, 2'b10, 1'b1, 1'b0);
        tick();
        DmacReq = 2'b00;
        tick();
        tick();
        checkOutput("rst_pre", 16'(channel_en_2), 16'h1);
        #1 rst = 1'b1;
        #1 checkOutput("rst_outs", 16'(allOuts()), 16'h0);
        C_config = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        checkOutput("rst_idle", 16'({busy, ReqAck, err}), 16'h0);
        checkOutput("sb_empty", 16'(sbQ.size()), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
